// File: rtl/i2c_player_slave.sv
// I2C target for a player board: three display registers written/read over I2C.
// SCL/SDA are oversampled on clk; SDA is driven open-drain for ACKs and read data.
module i2c_player_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010101,
   parameter int         NUM_REGS   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCL,
   inout  wire        SDA,
   output logic [7:0] reg0_q,
   output logic [7:0] reg1_q,
   output logic [7:0] reg2_q,
   output logic       wr_strobe,
   output logic [1:0] wr_reg,
   output logic       busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   localparam logic [8:0] NREG = 9'(NUM_REGS);

   state_t     state_q, state_d;
   logic [2:0] scl_q, sda_q;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
   logic [7:0] reg0_d, reg1_d, reg2_d, rd_val;
   logic       oe_q, oe_d, busy_q, busy_d, strobe_q, strobe_d;
   logic [1:0] wr_reg_q, wr_reg_d;
   logic       sda_in, scl_rise, scl_fall, start_c, stop_c, ptr_ok;

   // [1] is the synchronized level, [2] the previous synchronized level
   assign sda_in   = sda_q[1];
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start_c  = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop_c   = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign ptr_ok   = {1'b0, ptr_q} < NREG;

   assign SDA       = oe_q ? 1'b0 : 1'bz;
   assign busy      = busy_q;
   assign wr_strobe = strobe_q;
   assign wr_reg    = wr_reg_q;

   always_comb begin
      rd_val = 8'h00;
      if (ptr_ok) begin
         case (ptr_q)
            8'd0:    rd_val = reg0_q;
            8'd1:    rd_val = reg1_q;
            8'd2:    rd_val = reg2_q;
            default: rd_val = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      ptr_d    = ptr_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      strobe_d = 1'b0;
      wr_reg_d = wr_reg_q;
      reg0_d   = reg0_q;
      reg1_d   = reg1_q;
      reg2_d   = reg2_q;
      if (stop_c) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_c) begin
         state_d = ADDR;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_in};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  if (shift_q[6:0] == SLAVE_ADDR) begin
                     state_d = ADDR_ACK;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            // ACK states: first fall asserts the ACK, second fall ends it
            ADDR_ACK: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else if (shift_q[0]) begin
                  tx_d    = rd_val;
                  oe_d    = ~rd_val[7];
                  cnt_d   = 4'd0;
                  state_d = RDATA;
               end else begin
                  oe_d    = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = REG;
               end
            end
            REG: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_in};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  ptr_d   = {shift_q[6:0], sda_in};
                  state_d = REG_ACK;
               end
            end
            WDATA: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_in};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) state_d = WDATA_ACK;
            end
            REG_ACK, WDATA_ACK: begin
               if (scl_rise && oe_q && state_q == WDATA_ACK) begin
                  if (ptr_ok) begin
                     case (ptr_q)
                        8'd0:    reg0_d = shift_q;
                        8'd1:    reg1_d = shift_q;
                        8'd2:    reg2_d = shift_q;
                        default: ;
                     endcase
                     strobe_d = 1'b1;
                     wr_reg_d = ptr_q[1:0];
                  end
                  ptr_d = ptr_q + 8'd1;
               end
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d    = 1'b0;
                     cnt_d   = 4'd0;
                     state_d = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) cnt_d = cnt_q + 4'd1;
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     cnt_d   = 4'd0;
                     state_d = RDATA_ACK;
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                     oe_d = ~tx_q[6];
                  end
               end
            end
            // cnt_q==1 marks that the master ACKed and another byte follows
            RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda_in) begin
                     ptr_d = ptr_q + 8'd1;
                     cnt_d = 4'd1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  tx_d    = rd_val;
                  oe_d    = ~rd_val[7];
                  cnt_d   = 4'd0;
                  state_d = RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_q    <= 3'b000;
         sda_q    <= 3'b000;
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         shift_q  <= 8'h00;
         tx_q     <= 8'h00;
         ptr_q    <= 8'h00;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         wr_reg_q <= 2'd0;
         reg0_q   <= 8'h00;
         reg1_q   <= 8'h00;
         reg2_q   <= 8'h00;
      end else begin
         scl_q    <= {scl_q[1:0], SCL};
         sda_q    <= {sda_q[1:0], SDA};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         ptr_q    <= ptr_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         wr_reg_q <= wr_reg_d;
         reg0_q   <= reg0_d;
         reg1_q   <= reg1_d;
         reg2_q   <= reg2_d;
      end
   end
endmodule

// File: tb/tb_i2c_player_slave.sv
// Bench for i2c_player_slave: bit-banged I2C master, directed vectors and a
// randomized register-file reference model.
module tb_i2c_player_slave;
   localparam int         Q  = 8;
   localparam logic [6:0] SA = 7'h55;

   logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
   wire        SDA;
   logic [7:0] reg0_q, reg1_q, reg2_q;
   logic       wr_strobe, busy;
   logic [1:0] wr_reg;

   int   checks = 0, errors = 0;
   int   dut_low = 0, dbl = 0;
   logic strb_prev = 1'b0;
   logic [1:0] strb_q[$], exp_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] mem [3];

   typedef struct {
      logic [6:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       ack;
      logic       strb;
      logic [7:0] e0, e1, e2;
   } vec_t;
   vec_t v [6];

   assign SDA = m_sda ? 1'bz : 1'b0;
   pullup (SDA);
   always #5 clk = ~clk;

   i2c_player_slave #(.SLAVE_ADDR(SA), .NUM_REGS(3)) dut (
      .clk(clk), .rst(rst), .SCL(scl), .SDA(SDA),
      .reg0_q(reg0_q), .reg1_q(reg1_q), .reg2_q(reg2_q),
      .wr_strobe(wr_strobe), .wr_reg(wr_reg), .busy(busy)
   );

   always @(negedge clk) begin
      if (m_sda && SDA === 1'b0) dut_low <= dut_low + 1;
      if (wr_strobe) strb_q.push_back(wr_reg);
      if (wr_strobe && strb_prev) dbl <= dbl + 1;
      strb_prev <= wr_strobe;
   end

   initial begin
      #3ms;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   function automatic logic sda_bit();
      return (SDA === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq(); scl = 1'b1; wq(); m_sda = 1'b0; wq(); scl = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wq(); scl = 1'b1; wq(); m_sda = 1'b1; wq();
   endtask

   task automatic xfer_bit(input logic b, output logic s);
      m_sda = b; wq(); scl = 1'b1; wq(); s = sda_bit(); wq(); scl = 1'b0; wq();
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
      xfer_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d, output logic rel);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, s);
         d[i] = s;
      end
      xfer_bit(~mack, s);
      rel = s;
   endtask

   task automatic write_txn(input logic [7:0] p, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
      logic a;
      i2c_start();
      wr_byte({SA, 1'b0}, a); check("wt_addr_ack", a, 1);
      wr_byte(p, a);          check("wt_reg_ack", a, 1);
      for (int k = 0; k < n; k++) begin
         wr_byte((k == 0) ? b0 : (k == 1) ? b1 : b2, a);
         check("wt_data_ack", a, 1);
      end
      i2c_stop();
      check("wt_busy_stop", busy, 0);
   endtask

   task automatic read_txn(input logic [7:0] p, input int n);
      logic a, rel;
      logic [7:0] d;
      rd_q.delete();
      rel = 1'b0;
      i2c_start();
      wr_byte({SA, 1'b0}, a); check("rt_addrw_ack", a, 1);
      wr_byte(p, a);          check("rt_reg_ack", a, 1);
      i2c_start();
      wr_byte({SA, 1'b1}, a); check("rt_addrr_ack", a, 1);
      for (int k = 0; k < n; k++) begin
         rd_byte(k != n - 1, d, rel);
         rd_q.push_back(d);
      end
      check("rt_release", rel, 1);
      check("rt_busy", busy, 1);
      i2c_stop();
      check("rt_busy_stop", busy, 0);
   endtask

   task automatic check_strobes(input string nm);
      check({nm, "_cnt"}, strb_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check(nm, (k < strb_q.size()) ? 32'(strb_q[k]) : 32'hFF, 32'(exp_q[k]));
      strb_q.delete();
      exp_q.delete();
   endtask

   task automatic check_regs(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
      check({nm, "_r0"}, reg0_q, e0);
      check({nm, "_r1"}, reg1_q, e1);
      check({nm, "_r2"}, reg2_q, e2);
   endtask

   initial begin
      logic a, s, rel;
      logic [7:0] d;
      int dl;

      v[0] = '{SA,    8'h00, 8'h01, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00};
      v[1] = '{7'h2A, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00};
      v[2] = '{SA,    8'h05, 8'hAA, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00};
      v[3] = '{SA,    8'h02, 8'h07, 1'b1, 1'b1, 8'h01, 8'h00, 8'h07};
      v[4] = '{SA,    8'h02, 8'h00, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00};
      v[5] = '{SA,    8'h01, 8'h03, 1'b1, 1'b1, 8'h01, 8'h03, 8'h00};

      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_regs("reset", 8'h00, 8'h00, 8'h00);
      check("reset_strobe", wr_strobe, 0);
      check("reset_wr_reg", wr_reg, 0);
      check("reset_busy", busy, 0);
      check("reset_sda", sda_bit(), 1);
      strb_q.delete();

      for (int i = 0; i < 6; i++) begin
         dl = dut_low;
         i2c_start();
         wr_byte({v[i].addr, 1'b0}, a);
         check("vec_addr_ack", a, v[i].ack);
         if (v[i].ack) begin
            check("vec_busy_mid", busy, 1);
            wr_byte(v[i].ptr, a);  check("vec_reg_ack", a, 1);
            wr_byte(v[i].data, a); check("vec_data_ack", a, 1);
         end else begin
            check("vec_busy_nomatch", busy, 0);
            check("vec_no_drive", dut_low - dl, 0);
         end
         i2c_stop();
         check("vec_busy_stop", busy, 0);
         if (v[i].strb) begin
            exp_q.push_back(v[i].ptr[1:0]);
            check("vec_wr_reg", wr_reg, v[i].ptr[1:0]);
         end
         check_strobes("vec_strobe");
         check_regs("vec", v[i].e0, v[i].e1, v[i].e2);
      end

      write_txn(8'h01, 8'h02, 8'h02, 8'h00, 2);
      exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      check_strobes("burst_strobe");
      check_regs("burst", 8'h01, 8'h02, 8'h02);

      write_txn(8'h01, 8'h03, 8'h00, 8'h00, 1);
      exp_q.push_back(2'd1);
      check_strobes("rd_setup_strobe");
      read_txn(8'h01, 1);
      check("read_reg1", rd_q[0], 8'h03);
      read_txn(8'h05, 1);
      check("read_unimpl", rd_q[0], 8'h00);
      check_strobes("read_no_strobe");

      i2c_start();
      wr_byte({SA, 1'b0}, a);
      wr_byte(8'h00, a);
      for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
      i2c_stop();
      check_strobes("abort_strobe");
      check_regs("abort", 8'h01, 8'h03, 8'h02);
      check("abort_busy", busy, 0);

      i2c_start();
      xfer_bit(1'b1, s); xfer_bit(1'b0, s); xfer_bit(1'b1, s);
      rst = 1'b1;
      m_sda = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sda", sda_bit(), 1);
      check("rst_busy", busy, 0);
      check("rst_strobe", wr_strobe, 0);
      check_regs("rst", 8'h00, 8'h00, 8'h00);
      rst = 1'b0;
      dl = dut_low;
      xfer_bit(1'b0, s); xfer_bit(1'b1, s); xfer_bit(1'b0, s); xfer_bit(1'b1, s); xfer_bit(1'b0, s);
      xfer_bit(1'b1, s);
      check("rst_ignored_ack", s, 1);
      i2c_stop();
      check("rst_ignored_drive", dut_low - dl, 0);
      check("rst_busy_after", busy, 0);
      strb_q.delete();
      write_txn(8'h00, 8'h02, 8'h00, 8'h00, 1);
      exp_q.push_back(2'd0);
      check_strobes("post_rst_strobe");
      check_regs("post_rst", 8'h02, 8'h00, 8'h00);

      mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h00;
      for (int t = 0; t < 12; t++) begin
         logic [7:0] p, pp;
         logic [7:0] b [3];
         int n, sel;
         sel = int'($urandom_range(0, 7));
         p = (sel > 5) ? 8'(248 + sel) : 8'(sel);
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
         pp = p;
         if ($urandom_range(0, 1) == 1) begin
            write_txn(p, b[0], b[1], b[2], n);
            for (int k = 0; k < n; k++) begin
               if (pp < 8'd3) begin
                  mem[pp[1:0]] = b[k];
                  exp_q.push_back(pp[1:0]);
               end
               pp = pp + 8'd1;
            end
            check_strobes("rnd_strobe");
            check_regs("rnd", mem[0], mem[1], mem[2]);
         end else begin
            read_txn(p, n);
            for (int k = 0; k < n; k++) begin
               check("rnd_read", (k < rd_q.size()) ? 32'(rd_q[k]) : 32'h1FF,
                     (pp < 8'd3) ? 32'(mem[pp[1:0]]) : 32'h0);
               pp = pp + 8'd1;
            end
            check_strobes("rnd_rd_strobe");
         end
      end

      check("no_double_strobe", dbl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
